// File: rtl/des_ip_loader.sv
// rtl/des_ip_loader.sv - byte-serial DES block loader applying the initial permutation (optional abort: DES_IP_LOADER_ABORT_EN)
module des_ip_loader #(
    parameter int BYTE_MSB_FIRST = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_byte,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_l,
    output logic [31:0] out_r,
`ifdef DES_IP_LOADER_ABORT_EN
    input  logic        abort,
`endif
    output logic        err
);

    logic [2:0]  cnt;
    logic [63:0] asm_word;
    logic [63:0] asm_next;
    logic [63:0] ip_word;
    logic [2:0]  lane;
    logic [5:0]  lane_lsb;
    logic        abort_act;
    logic        xfer;
    logic        load;

`ifdef DES_IP_LOADER_ABORT_EN
    assign abort_act = abort;
`else
    assign abort_act = 1'b0;
`endif

    // IP table rows follow a regular pattern: even source positions first, then odd.
    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y;
        int          src;
        y = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                src = (r < 4) ? (58 + 2 * r - 8 * c) : (57 + 2 * (r - 4) - 8 * c);
                y[63 - (8 * r + c)] = x[64 - src];
            end
        end
        return y;
    endfunction

    assign in_ready = !(cnt == 3'd7 && out_valid && !out_ready);
    assign xfer     = in_valid && in_ready && !abort_act;
    assign load     = xfer && (cnt == 3'd7);

    assign lane     = (BYTE_MSB_FIRST != 0) ? (3'd7 - cnt) : cnt;
    assign lane_lsb = {lane, 3'b000};

    always_comb begin
        asm_next = asm_word;
        asm_next[lane_lsb +: 8] = in_byte;
    end

    assign ip_word = ip_perm(asm_next);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= 3'd0;
            asm_word <= 64'd0;
            err      <= 1'b0;
        end else begin
            err <= 1'b0;
            if (abort_act) begin
                cnt      <= 3'd0;
                asm_word <= 64'd0;
            end else if (xfer) begin
                if (cnt == 3'd7) begin
                    cnt      <= 3'd0;
                    asm_word <= 64'd0;
                    err      <= !in_last;
                end else if (in_last) begin
                    cnt      <= 3'd0;
                    asm_word <= 64'd0;
                    err      <= 1'b1;
                end else begin
                    cnt      <= cnt + 3'd1;
                    asm_word <= asm_next;
                end
            end
        end
    end

    // A completing byte may reload the output in the same cycle it is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_l     <= 32'd0;
            out_r     <= 32'd0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                out_l     <= ip_word[63:32];
                out_r     <= ip_word[31:0];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_des_ip_loader.sv
// tb/tb_des_ip_loader.sv - directed and FP round-trip checks for des_ip_loader
module tb_des_ip_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_byte = 8'd0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_l;
    logic [31:0] out_r;
    logic        err;
`ifdef DES_IP_LOADER_ABORT_EN
    logic        abort = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    localparam int FP_TAB [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,
        39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,
        37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,
        35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,
        33, 1, 41, 9,  49, 17, 57, 25
    };

    des_ip_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_byte   (in_byte),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_l     (out_l),
        .out_r     (out_r),
`ifdef DES_IP_LOADER_ABORT_EN
        .abort     (abort),
`endif
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, need completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, need %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] fp(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[63 - i] = x[64 - FP_TAB[i]];
        return y;
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic last);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_byte  = b;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_block(input logic [63:0] blk);
        for (int k = 0; k < 8; k++) send_byte(blk[63 - 8 * k -: 8], k == 7);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [63:0] blk;

    initial begin
        #12;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out", {out_l, out_r}, 64'd0);
        check("reset_err", 64'(err), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        tick();

        send_block(64'h0123456789ABCDEF);
        check("v1_valid", 64'(out_valid), 64'd1);
        check("v1_data", {out_l, out_r}, 64'hCC00CCFF_F0AAF0AA);
        check("v1_err", 64'(err), 64'd0);
        tick();
        check("v1_valid_clear", 64'(out_valid), 64'd0);

        send_block(64'h8000000000000000);
        check("bit_data", {out_l, out_r}, 64'h00000000_01000000);
        send_block(64'hFFFFFFFFFFFFFFFF);
        check("ones_data", {out_l, out_r}, 64'hFFFFFFFF_FFFFFFFF);
        tick();

        // Backpressure: second block fills behind a held first block.
        out_ready = 1'b0;
        send_block(64'h0123456789ABCDEF);
        for (int k = 0; k < 7; k++) send_byte(8'hFF, 1'b0);
        check("bp_held", {out_l, out_r}, 64'hCC00CCFF_F0AAF0AA);
        in_valid = 1'b1;
        in_byte  = 8'hFF;
        in_last  = 1'b1;
        @(negedge clk);
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        check("bp_held_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("bp_swap_valid", 64'(out_valid), 64'd1);
        check("bp_swap_data", {out_l, out_r}, 64'hFFFFFFFF_FFFFFFFF);
        tick();
        check("bp_drain", 64'(out_valid), 64'd0);

        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b1);
        check("early_last_err", 64'(err), 64'd1);
        check("early_last_no_out", 64'(out_valid), 64'd0);
        tick();
        check("early_last_err_pulse", 64'(err), 64'd0);
        send_block(64'h8000000000000000);
        check("after_err_data", {out_l, out_r}, 64'h00000000_01000000);
        check("after_err_err", 64'(err), 64'd0);
        for (int k = 0; k < 8; k++) begin
            blk = 64'h0123456789ABCDEF;
            send_byte(blk[63 - 8 * k -: 8], 1'b0);
        end
        check("no_last_err", 64'(err), 64'd1);
        check("no_last_valid", 64'(out_valid), 64'd1);
        check("no_last_data", {out_l, out_r}, 64'hCC00CCFF_F0AAF0AA);
        tick();

        for (int i = 0; i < 50; i++) begin
            blk = {$urandom, $urandom};
            send_block(blk);
            check("fp_roundtrip", fp({out_l, out_r}), blk);
        end
        tick();

        out_ready = 1'b0;
        send_block(64'hFFFFFFFFFFFFFFFF);
        for (int k = 0; k < 4; k++) send_byte(8'hA5, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_data", {out_l, out_r}, 64'd0);
        check("async_rst_in_ready", 64'(in_ready), 64'd1);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        send_block(64'h0123456789ABCDEF);
        check("post_rst_data", {out_l, out_r}, 64'hCC00CCFF_F0AAF0AA);
        tick();

`ifdef DES_IP_LOADER_ABORT_EN
        for (int k = 0; k < 4; k++) send_byte(8'h5A, 1'b0);
        abort = 1'b1;
        send_byte(8'h5A, 1'b0);
        abort = 1'b0;
        check("abort_no_err", 64'(err), 64'd0);
        check("abort_no_out", 64'(out_valid), 64'd0);
        send_block(64'h8000000000000000);
        check("abort_next_data", {out_l, out_r}, 64'h00000000_01000000);
        out_ready = 1'b0;
        tick();
        send_byte(8'h01, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_held_valid", 64'(out_valid), 64'd1);
        check("abort_held_data", {out_l, out_r}, 64'h00000000_01000000);
        out_ready = 1'b1;
        tick();
        send_block(64'h0123456789ABCDEF);
        check("abort_after_data", {out_l, out_r}, 64'hCC00CCFF_F0AAF0AA);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/des_ip_loader.md
# des_ip_loader

Byte-serial input stage of the DES datapath. It collects eight plaintext or ciphertext bytes over a valid/ready stream, applies the DES initial permutation (IP, FIPS 46-3), and presents the permuted block as the L0/R0 halves to the round engine. It is the entry-side counterpart of the existing final-permutation block: FP(IP(x)) = x for every 64-bit x.

## Interface
- BYTE_MSB_FIRST, 1, 1: first accepted byte is block bits [63:56]. 0: first byte is bits [7:0].
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_byte/in_last valid
- in_ready  output  1  loader can accept a byte this cycle
- in_byte  input  8  block byte
- in_last  input  1  marks the eighth byte of a block
- out_valid  output  1  out_l/out_r hold a permuted block
- out_ready  input  1  consumer accepts the block
- out_l  output  32  IP result bits [63:32] (L0)
- out_r  output  32  IP result bits [31:0] (R0)
- err  output  1  one-cycle pulse on framing error
- abort  input  1  present only with DES_IP_LOADER_ABORT_EN

## Operation
- Byte transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
- A 3-bit byte counter cnt (0..7) and a 64-bit assembly register track the block being filled. Each accepted byte goes into the lane selected by cnt and BYTE_MSB_FIRST.
- Completing transfer (cnt==7): IP is applied combinationally to the assembled word, including the eighth byte. The result loads the output register, out_valid sets, and cnt returns to 0.
- IP mapping, 1 = MSB of output taken from input position, 1 = MSB:
  - 58 50 42 34 26 18 10 2
  - 60 52 44 36 28 20 12 4
  - 62 54 46 38 30 22 14 6
  - 64 56 48 40 32 24 16 8
  - 57 49 41 33 25 17 9 1
  - 59 51 43 35 27 19 11 3
  - 61 53 45 37 29 21 13 5
  - 63 55 47 39 31 23 15 7
- in_ready = !(cnt==7 && out_valid && !out_ready).
  - Bytes 0..6 of the next block may be accepted while the output register is still held.
- out_l/out_r stay stable while out_valid && !out_ready.
- out_valid clears on an output transfer unless a new block loads in the same cycle. If a new block loads in that cycle, out_valid stays 1 with the new data.
- Framing errors:
  - in_last accepted with cnt!=7: err pulses, the partial block is discarded, cnt goes to 0, nothing is emitted.
  - cnt==7 transfer without in_last: err pulses and the block is still emitted normally.

## Timing
- Reset values: out_valid=0, out_l=0, out_r=0, err=0, cnt=0, assembly register 0, in_ready=1.
- Latency: out_valid rises on the clock edge that captures the eighth byte, so it is visible in the cycle after that transfer.
- Sustained throughput: one byte per cycle and one block per 8 cycles, with no bubbles when out_ready is held at 1.
- err is registered and is high for exactly the cycle after the offending transfer.
- Reset asserted mid-block discards the partial block and any held output immediately, without waiting for a clock edge.

## Configuration
- DES_IP_LOADER_ABORT_EN defined:
  - Adds a synchronous `abort` input.
  - While abort is high, cnt and the assembly register clear, and any byte offered that cycle is dropped. in_ready still reads as computed, and the dropped byte is not counted.
  - The output register and out_valid are unaffected.
  - Abort takes priority over in_last error handling; err stays 0.
- Not defined: no abort port. Partial blocks clear only through reset or an in_last framing error.

## Test plan
- BYTE_MSB_FIRST=1, bytes 01 23 45 67 89 AB CD EF with in_last on EF -> next cycle out_valid=1, out_l=CC00CCFF, out_r=F0AAF0AA, err=0.
- Single-bit block 80 00 00 00 00 00 00 00 -> out_l=00000000, out_r=01000000. All-FF block -> out_l=out_r=FFFFFFFF.
- out_ready=0 while two blocks are streamed -> second block's bytes 0..6 accepted, in_ready=0 at its byte 7, first block held stable. out_ready=1 -> first block transfers, second loads the same cycle, out_valid stays 1.
- in_last on the 3rd byte -> err pulse, no output, following 8 bytes form a correct block. 8th byte without in_last -> err pulse and block emitted.
- 50 random blocks through des_ip_loader then the existing final-permutation block -> output equals the original 64-bit input. rst_n pulsed after byte 4 -> all outputs reset, next full block correct.
- With DES_IP_LOADER_ABORT_EN: abort on byte 5 -> no output, err=0. The next 8 bytes yield the correct block. A held output is unaffected by the abort.
